rs_bank: RTL and testbench

Parametrised reservation-station bank replacing the fixed four-station wrapper between issue and the execute units. It holds `NUM_ENTRIES` waiting instructions and allocates new ones into the lowest free slot through a valid/ready handshake. Every entry snoops the CDB and wakes up when its operands arrive. Each cycle it issues the oldest ready entry to its functional unit through a second valid/ready handshake, so the issue stage no longer has to pick a station number.

---
 rtl/rs_bank_pkg.sv | 74 +++++++
 rtl/rs_entry.sv | 63 ++++++
 rtl/rs_bank.sv | 90 +++++++++
 tb/tb_rs_bank.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_bank_pkg.sv
// Shared types for the reservation-station bank: CDB packet, station contents and issue bundle.
// Tag and data widths live here because the packed structs that cross the bank's ports carry them.
package rs_bank_pkg;

    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [3:0] {
        NOP     = 4'd0,
        ALU_ADD = 4'd1,
        ALU_SUB = 4'd2,
        ALU_AND = 4'd3,
        ALU_OR  = 4'd4,
        ALU_XOR = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_t;

    typedef enum logic [2:0] {
        NB     = 3'd0,
        BR_EQ  = 3'd1,
        BR_NE  = 3'd2,
        BR_LT  = 3'd3,
        BR_GE  = 3'd4,
        BR_JAL = 3'd5
    } branch_t;

    typedef struct packed {
        tag_t    q_j;
        tag_t    q_k;
        word_t   v_j;
        word_t   v_k;
        logic    load;
        tag_t    rob_entry;
        alu_op_t alu_op;
        branch_t branch_type;
    } rs_data_t;

    typedef struct packed {
        logic  valid;
        tag_t  dest_rob_entry;
        word_t result;
        logic  load_step1;
    } cdb_packet_t;

    typedef struct packed {
        alu_op_t alu_op;
        tag_t    rob_entry;
        branch_t branch_type;
        word_t   rs1;
        word_t   rs2;
        logic    load;
    } rs_out_t;

    localparam rs_data_t RS_EMPTY = '{
        q_j: '0, q_k: '0, v_j: '0, v_k: '0, load: 1'b0,
        rob_entry: '0, alu_op: NOP, branch_type: NB
    };

    function automatic rs_out_t to_out(input rs_data_t d);
        rs_out_t o;
        o.alu_op      = d.alu_op;
        o.rob_entry   = d.rob_entry;
        o.branch_type = d.branch_type;
        o.rs1         = d.v_j;
        o.rs2         = d.v_k;
        o.load        = d.load;
        return o;
    endfunction

endpackage

// File: rtl/rs_entry.sv
// One reservation station: holds an instruction, snoops the CDB for its operands,
// applies the allocation bypass, and reports when it is ready to issue.
module rs_entry
    import rs_bank_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        alloc_en,
    input  logic        free_en,
    input  rs_data_t    alloc_d,
    input  cdb_packet_t cdb_in,
    output logic        valid,
    output logic        ready,
    output rs_out_t     issue_out
);

    rs_data_t data;
    logic     wake;
    logic     hit_j, hit_k, byp_j, byp_k;

    // Load first-step broadcasts carry an address, not a value, so they never wake anyone.
    assign wake  = cdb_in.valid & ~cdb_in.load_step1;
    assign hit_j = wake && (data.q_j != '0) && (data.q_j == cdb_in.dest_rob_entry);
    assign hit_k = wake && (data.q_k != '0) && (data.q_k == cdb_in.dest_rob_entry);
    assign byp_j = wake && (alloc_d.q_j != '0) && (alloc_d.q_j == cdb_in.dest_rob_entry);
    assign byp_k = wake && (alloc_d.q_k != '0) && (alloc_d.q_k == cdb_in.dest_rob_entry);

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every station samples the same pre-edge CDB and control values.
        if (!reset || flush) begin
            valid <= 1'b0;
            data  <= RS_EMPTY;
        end else if (alloc_en) begin
            valid <= 1'b1;
            data  <= alloc_d;
            if (byp_j) begin
                data.q_j <= '0;
                data.v_j <= cdb_in.result;
            end
            if (byp_k) begin
                data.q_k <= '0;
                data.v_k <= cdb_in.result;
            end
        end else if (free_en) begin
            valid <= 1'b0;
            data  <= RS_EMPTY;
        end else begin
            if (hit_j) begin
                data.q_j <= '0;
                data.v_j <= cdb_in.result;
            end
            if (hit_k) begin
                data.q_k <= '0;
                data.v_k <= cdb_in.result;
            end
        end
    end

    assign ready     = valid && (data.q_j == '0) && (data.q_k == '0) && (data.rob_entry != '0);
    assign issue_out = to_out(data);

endmodule

// File: rtl/rs_bank.sv
// Reservation-station bank: lowest-free-slot allocation, age-ordered issue of the oldest
// ready station, and an occupancy count; flush and reset empty every station.
module rs_bank
    import rs_bank_pkg::*;
#(
    parameter  int NUM_ENTRIES = 4,
    localparam int OCC_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  rs_data_t         alloc_d,
    input  cdb_packet_t      cdb_in,
    output logic             issue_valid,
    input  logic             issue_ready,
    output rs_out_t          issue_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [NUM_ENTRIES-1:0] ent_valid, ent_ready;
    logic [NUM_ENTRIES-1:0] free_slot, alloc_vec, sel_vec, free_vec;
    rs_out_t                ent_out [NUM_ENTRIES];
    // older[i][j] set means station j was allocated before station i.
    logic [NUM_ENTRIES-1:0] older   [NUM_ENTRIES];
    logic                   alloc_fire, issue_fire;

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
        rs_entry u_entry (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .alloc_en  (alloc_vec[g]),
            .free_en   (free_vec[g]),
            .alloc_d   (alloc_d),
            .cdb_in    (cdb_in),
            .valid     (ent_valid[g]),
            .ready     (ent_ready[g]),
            .issue_out (ent_out[g])
        );
    end

    always_comb begin
        // NOTE: default first, so no path through the loop leaves the value held (no latch).
        free_slot = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) free_slot = NUM_ENTRIES'(1) << i;
        end
    end

    assign alloc_ready = ~(&ent_valid) & ~flush;
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign alloc_vec   = alloc_fire ? free_slot : '0;

    // A ready station wins when no ready station is older than it; age is a total order over valid stations.
    always_comb begin
        sel_vec    = '0;
        issue_data = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            sel_vec[i] = ent_ready[i] && ((older[i] & ent_ready) == '0);
            if (sel_vec[i]) issue_data = ent_out[i];
        end
    end

    assign issue_valid = (|ent_ready) & ~flush;
    assign issue_fire  = issue_valid & issue_ready;
    assign free_vec    = issue_fire ? sel_vec : '0;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!reset || flush || free_vec[i]) begin
                older[i] <= '0;
            end else if (alloc_vec[i]) begin
                older[i] <= ent_valid & ~free_vec;
            end else begin
                older[i] <= older[i] & ~free_vec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(alloc_fire) - OCC_W'(issue_fire);
        end
    end

endmodule

// File: tb/tb_rs_bank.sv
// Self-checking bench for rs_bank: an age-ordered queue model predicts every issue,
// and a negedge monitor pops and compares whenever the bank hands an instruction to the FU.
module tb_rs_bank;
    import rs_bank_pkg::*;

    localparam int N     = 4;
    localparam int OCC_W = $clog2(N + 1);

    logic             clk = 1'b0;
    logic             reset, flush, alloc_valid, alloc_ready;
    logic             issue_valid, issue_ready;
    rs_data_t         alloc_d;
    cdb_packet_t      cdb_in;
    rs_out_t          issue_data;
    logic [OCC_W-1:0] occupancy;

    int       checks   = 0;
    int       failures = 0;
    rs_out_t  sb [$];
    rs_data_t mq [$];
    rs_out_t  mon_exp;

    always #5 clk = ~clk;

    rs_bank #(.NUM_ENTRIES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .alloc_valid (alloc_valid),
        .alloc_ready (alloc_ready),
        .alloc_d     (alloc_d),
        .cdb_in      (cdb_in),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_data  (issue_data),
        .occupancy   (occupancy)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rs_out_t expect_out(input rs_data_t d);
        rs_out_t o;
        o.alu_op      = d.alu_op;
        o.rob_entry   = d.rob_entry;
        o.branch_type = d.branch_type;
        o.rs1         = d.v_j;
        o.rs2         = d.v_k;
        o.load        = d.load;
        return o;
    endfunction

    function automatic bit is_ready(input rs_data_t d);
        return d.q_j == '0 && d.q_k == '0 && d.rob_entry != '0;
    endfunction

    // The model queue is kept oldest-first, so the first ready element is the one to issue.
    function automatic int oldest_ready();
        foreach (mq[i]) if (is_ready(mq[i])) return i;
        return -1;
    endfunction

    function automatic rs_data_t snoop(input rs_data_t d, input cdb_packet_t cb);
        rs_data_t r = d;
        if (cb.valid && !cb.load_step1) begin
            if (r.q_j != '0 && r.q_j == cb.dest_rob_entry) begin r.q_j = '0; r.v_j = cb.result; end
            if (r.q_k != '0 && r.q_k == cb.dest_rob_entry) begin r.q_k = '0; r.v_k = cb.result; end
        end
        return r;
    endfunction

    function automatic rs_data_t mk(input int rob, input int qj, input int qk, input logic [31:0] vj, input logic [31:0] vk);
        rs_data_t d = '0;
        d.rob_entry   = tag_t'(rob);
        d.q_j         = tag_t'(qj);
        d.q_k         = tag_t'(qk);
        d.v_j         = vj;
        d.v_k         = vk;
        d.alu_op      = ALU_ADD;
        d.branch_type = NB;
        return d;
    endfunction

    function automatic cdb_packet_t bc(input int tag, input logic [31:0] res, input bit ls1);
        cdb_packet_t c;
        c.valid          = 1'b1;
        c.dest_rob_entry = tag_t'(tag);
        c.result         = res;
        c.load_step1     = ls1;
        return c;
    endfunction

    // Called at posedge+1: drive one cycle of inputs, check outputs against the model, advance the model.
    task automatic cycle(input bit av, input rs_data_t ad, input cdb_packet_t cb,
                         input bit ir, input bit fl, input bit rst);
        int       sel, pre;
        bit       exp_ar, exp_iv;
        rs_data_t d;
        alloc_valid = av; alloc_d = ad; cdb_in = cb;
        issue_ready = ir; flush = fl; reset = rst;
        #1;
        sel    = oldest_ready();
        exp_ar = !fl && mq.size() < N;
        exp_iv = !fl && sel >= 0;
        check("alloc_ready", 128'(alloc_ready), 128'(exp_ar));
        check("issue_valid", 128'(issue_valid), 128'(exp_iv));
        check("occupancy", 128'(occupancy), 128'(mq.size()));
        if (exp_iv) check("issue_data_sel", 128'(issue_data), 128'(expect_out(mq[sel])));
        if (exp_iv && ir) sb.push_back(expect_out(mq[sel]));
        if (!rst || fl) begin
            mq.delete();
        end else begin
            pre = mq.size();
            if (exp_iv && ir) mq.delete(sel);
            foreach (mq[i]) mq[i] = snoop(mq[i], cb);
            if (av && pre < N) begin
                d = snoop(ad, cb);
                mq.push_back(d);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ir);
        cycle(1'b0, '0, '0, ir, 1'b0, 1'b1);
    endtask

    task automatic check_reset_outputs();
        check("rst_alloc_ready", 128'(alloc_ready), 128'(1));
        check("rst_issue_valid", 128'(issue_valid), 128'(0));
        check("rst_issue_data", 128'(issue_data), 128'(0));
        check("rst_occupancy", 128'(occupancy), 128'(0));
    endtask

    always @(negedge clk) begin
        if (issue_valid === 1'b1 && issue_ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue: got rob %0d, expected no issue at %0t", issue_data.rob_entry, $time);
            end else begin
                mon_exp = sb.pop_front();
                check("issue_fire_data", 128'(issue_data), 128'(mon_exp));
            end
        end
    end

    initial begin
        rs_data_t    rd;
        cdb_packet_t rc;
        reset = 1'b0; flush = 1'b0; alloc_valid = 1'b0; issue_ready = 1'b0;
        alloc_d = '0; cdb_in = '0;
        @(posedge clk);
        #1;
        check_reset_outputs();

        // Fill and drain, with backpressure and an ignored allocation while full.
        for (int r = 1; r <= N; r++) cycle(1'b1, mk(r, 0, 0, 32'(r * 16), 32'(r * 32)), '0, 1'b0, 1'b0, 1'b1);
        check("full_occupancy", 128'(occupancy), 128'(N));
        check("full_alloc_ready", 128'(alloc_ready), 128'(0));
        cycle(1'b1, mk(9, 0, 0, 32'h9, 32'h9), '0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            check("backpressure_rob", 128'(issue_data.rob_entry), 128'(1));
            idle(1'b0);
        end
        for (int r = 0; r < N; r++) idle(1'b1);
        check("drained_occupancy", 128'(occupancy), 128'(0));

        // Wakeup: a load first-step broadcast is ignored, a normal one wakes Q_j.
        cycle(1'b1, mk(5, 3, 0, 32'h0, 32'h55), '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, '0, bc(3, 32'hCAFEF00D, 1'b1), 1'b0, 1'b0, 1'b1);
        check("ls1_no_wake", 128'(issue_valid), 128'(0));
        cycle(1'b0, '0, bc(3, 32'hDEADBEEF, 1'b0), 1'b0, 1'b0, 1'b1);
        check("wake_valid", 128'(issue_valid), 128'(1));
        check("wake_rs1", 128'(issue_data.rs1), 128'(32'hDEADBEEF));
        idle(1'b1);

        // Allocation bypass on Q_k.
        cycle(1'b1, mk(6, 0, 7, 32'h66, 32'h0), bc(7, 32'h1234, 1'b0), 1'b0, 1'b0, 1'b1);
        check("bypass_rs2", 128'(issue_data.rs2), 128'(32'h1234));
        idle(1'b1);

        // Age order: the younger ready entry goes first, the older one after its wakeup.
        cycle(1'b1, mk(10, 9, 0, 32'h0, 32'hA), '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(11, 0, 0, 32'hB, 32'hB), '0, 1'b0, 1'b0, 1'b1);
        check("age_first_rob", 128'(issue_data.rob_entry), 128'(11));
        idle(1'b1);
        cycle(1'b0, '0, bc(9, 32'h99, 1'b0), 1'b1, 1'b0, 1'b1);
        check("age_second_rob", 128'(issue_data.rob_entry), 128'(10));
        idle(1'b1);

        // Flush with three waiting entries.
        for (int r = 1; r <= 3; r++) cycle(1'b1, mk(r, 15, 0, 32'h0, 32'h0), '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(4, 0, 0, 32'h4, 32'h4), '0, 1'b1, 1'b1, 1'b1);
        check("flush_occupancy", 128'(occupancy), 128'(0));
        check("flush_issue_valid", 128'(issue_valid), 128'(0));

        // Reset mid-stream with three ready entries.
        for (int r = 1; r <= 3; r++) cycle(1'b1, mk(r, 0, 0, 32'(r), 32'(r)), '0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, mk(4, 0, 0, 32'h4, 32'h4), '0, 1'b1, 1'b0, 1'b0);
        check_reset_outputs();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            rd             = '0;
            rd.rob_entry   = ($urandom_range(0, 15) == 0) ? tag_t'(0) : tag_t'($urandom_range(1, 15));
            rd.q_j         = ($urandom_range(0, 1) == 0) ? tag_t'(0) : tag_t'($urandom_range(1, 15));
            rd.q_k         = ($urandom_range(0, 1) == 0) ? tag_t'(0) : tag_t'($urandom_range(1, 15));
            rd.v_j         = $urandom;
            rd.v_k         = $urandom;
            rd.load        = 1'($urandom_range(0, 1));
            rd.alu_op      = alu_op_t'($urandom_range(0, 7));
            rd.branch_type = branch_t'($urandom_range(0, 5));
            rc             = '0;
            if ($urandom_range(0, 9) < 6) rc = bc($urandom_range(1, 15), $urandom, $urandom_range(0, 9) == 0);
            cycle(1'($urandom_range(0, 1)), rd, rc, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) != 0);
        end

        idle(1'b0);
        check("scoreboard_drained", 128'(sb.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
